// File: rtl/stall_request_latch.sv
// Stall request latch: turns rising edges on 8 raw hazard lines into sticky,
// maskable pending requests for the stall priority encoder.
// Latency: 1 cycle from req_in edge to pend_out (3 cycles with REQ_SYNC_EN).
// Backpressure: none; requests are held until serviced, and lost ones raise overflow.
// Optional macro REQ_SYNC_EN inserts a two-flop synchronizer on req_in.
module stall_request_latch (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_in,
  input  logic       mask_wr,
  input  logic [7:0] mask_data,
  input  logic       svc_valid,
  input  logic [2:0] svc_idx,
  input  logic       ovf_clr,
  output logic [7:0] pend_out,
  output logic       enc_en,
  output logic [7:0] overflow,
  output logic       svc_err,
  output logic [3:0] pend_count
);

  // Source count is tied to the 3-bit encoder index.
  localparam int NREQ = 8;

  logic [NREQ-1:0] req_s;
  logic [NREQ-1:0] req_prev_q;
  logic [NREQ-1:0] pend_q, pend_d;
  logic [NREQ-1:0] mask_q, mask_d;
  logic [NREQ-1:0] ovf_q, ovf_d;
  logic            svc_err_q, svc_err_d;
  logic [NREQ-1:0] set_vec;
  logic [NREQ-1:0] clr_vec;

`ifdef REQ_SYNC_EN
  logic [NREQ-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer for request lines from a foreign clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= req_in;
      sync2_q <= sync1_q;
    end
  end

  assign req_s = sync2_q;
`else
  // Integrator guarantees req_in is already synchronous to clk.
  assign req_s = req_in;
`endif

  // Rising-edge detect and service one-hot decode.
  always_comb begin
    set_vec = req_s & ~req_prev_q;
    clr_vec = '0;
    if (svc_valid) begin
      clr_vec[svc_idx] = 1'b1;
    end
  end

  // Next-state for pending, overflow, mask and the service error pulse.
  always_comb begin
    // A same-cycle set beats the clear, so a fresh request is never dropped.
    pend_d    = (pend_q & ~clr_vec) | set_vec;
    // A new overflow event beats ovf_clr so no loss goes unreported.
    ovf_d     = (ovf_clr ? '0 : ovf_q) | (set_vec & pend_q & ~clr_vec);
    mask_d    = mask_wr ? mask_data : mask_q;
    // Masked-but-pending still counts as pending, so it is not an error.
    svc_err_d = svc_valid & ~pend_q[svc_idx];
  end

  // State registers; reset discards all pending work without flagging errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_prev_q <= '0;
      pend_q     <= '0;
      mask_q     <= '0;
      ovf_q      <= '0;
      svc_err_q  <= 1'b0;
    end else begin
      req_prev_q <= req_s;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      ovf_q      <= ovf_d;
      svc_err_q  <= svc_err_d;
    end
  end

  // Encoder-facing outputs, combinational from registers.
  always_comb begin
    pend_out   = pend_q & ~mask_q;
    enc_en     = |pend_out;
    pend_count = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend_count = pend_count + {3'b000, pend_out[i]};
    end
  end

  assign overflow = ovf_q;
  assign svc_err  = svc_err_q;

endmodule

// File: doc/stall_request_latch.md
Name: stall_request_latch

Overview:
- Upstream neighbour of the pipeline stall priority encoder.
- Captures rising edges on 8 raw hazard/stall request lines into sticky pending bits, applies a software mask, and drives the encoder's 8-bit request vector and enable.
- Clears a pending bit when the downstream stall logic reports that source serviced.
- Flags lost requests (overflow) and bogus service reports.

Parameters:
- NREQ, 8, number of request sources; fixed at 8 to match the 3-bit encoder index. Other values are unsupported.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_in  input  8  raw request lines; a rising edge raises a request
- mask_wr  input  1  load mask register from mask_data
- mask_data  input  8  1 = source masked (held, not presented)
- svc_valid  input  1  one-cycle strobe: source svc_idx has been serviced
- svc_idx  input  3  index of the serviced source
- ovf_clr  input  1  clear all overflow flags
- pend_out  output  8  pending & ~mask; feeds encoder request input
- enc_en  output  1  |pend_out; feeds encoder enable
- overflow  output  8  sticky per-source lost-request flags
- svc_err  output  1  one-cycle pulse: service reported for a source not pending
- pend_count  output  4  population count of pend_out, 0..8

Behaviour:
- Reset (async assert, sync-free release): pending=0, mask=0, overflow=0, req_prev=0, svc_err=0. Hence pend_out=0, enc_en=0, pend_count=0.
- Edge detect: set_vec = req_in & ~req_prev. req_prev <= req_in every cycle.
- Clear vector: clr_vec = onehot(svc_idx) when svc_valid, else 0.
- Pending update per bit: pending <= (pending & ~clr_vec) | set_vec.
  - Set and clear on the same bit in the same cycle: set wins, bit stays 1, no overflow.
- Overflow per bit: set when set_vec[i] & pending[i] & ~clr_vec[i].
  - Cleared by ovf_clr.
  - ovf_clr and a new overflow event in the same cycle: the event wins, bit = 1.
- svc_err: registered pulse, 1 the cycle after svc_valid names a bit that is 0 in pending. Masked-but-pending counts as pending, so no error. Pending is unchanged by an erroneous service.
- Mask:
  - mask_wr loads mask at the edge; the new mask affects pend_out from the next cycle.
  - Masked bits still capture and hold pending state and still flag overflow. Unmasking exposes them immediately.
- Outputs: pend_out, enc_en and pend_count are combinational from registers.
- Latency: req_in rising edge sampled at edge N → pend_out bit visible after edge N, i.e. 1 cycle.
- A held-high req_in raises exactly one request; a new request needs a low-then-high transition.
- Reset mid-operation: all state is cleared immediately, pending requests are discarded, and no svc_err is generated.
- Multiple simultaneous edges: all are captured; the encoder resolves order (lowest index first).

Optional Feature:
- Macro REQ_SYNC_EN.
- Defined: req_in passes through a two-flop synchronizer, reset to 0, before edge detection. Capture latency becomes 3 cycles (edge at N → pend_out after N+2), and pulses shorter than one clock may be missed.
- Undefined: req_in is used directly, with 1-cycle latency. The integrator guarantees req_in is synchronous to clk.

Test Plan:
- Reset then req_in 0x00→0x05 → after 1 edge pend_out=0x05, enc_en=1, pend_count=2. With REQ_SYNC_EN, after 3 edges.
- pending=0x05, svc_valid=1, svc_idx=0 → pend_out=0x04, pend_count=1, svc_err=0. Then svc_idx=2 → pend_out=0x00, enc_en=0.
- pending=0x08: drop req_in[3] then raise it again with no service → overflow=0x08, pend_out still 0x08. ovf_clr=1 → overflow=0x00.
- Bit 4 pending; new rising edge on req_in[4] in the same cycle as svc_valid, svc_idx=4 → pend_out[4]=1, overflow[4]=0.
- mask_wr with 0x02, then req_in edge on bit 1 → pend_out=0x00, enc_en=0. mask_wr with 0x00 → pend_out=0x02 next cycle.
- pending=0x00, svc_valid=1, svc_idx=6 → svc_err pulses 1 for one cycle, pending stays 0x00. Assert rst_n=0 mid-stream with pending=0xFF → all outputs 0 asynchronously.
